// File: rtl/pattern_stream_gen.sv
// Streams the ASCII bytes of a pyramid or diamond star pattern over valid/ready.
// Size and shape are latched per run; every output is a registered flop.
module pattern_stream_gen #(
    parameter int unsigned MAX_N = 16,
    parameter int unsigned NW    = $clog2(MAX_N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n_in,
    input  logic [1:0]    mode,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_NL   = 8'h0A;

    typedef enum logic [2:0] {IDLE, SPC, STAR, GAP, EOL} state_t;

    state_t        state, state_n;
    logic [NW-1:0] row, row_n, sp_cnt, sp_cnt_n, st_cnt, st_cnt_n, n_lat, n_lat_n;
    logic          half, half_n;
    logic [1:0]    mode_lat, mode_lat_n;
    logic [7:0]    data_n;
    logic          valid_n, last_n, busy_n, done_n, err_n;

    // Leading spaces for a row; half=0 is the up pyramid, half=1 the down one
    function automatic logic [NW-1:0] row_s(input logic h, input logic [NW-1:0] r,
                                            input logic [NW-1:0] n);
        return h ? r : n - r - NW'(1);
    endfunction

    function automatic logic [NW-1:0] row_k(input logic h, input logic [NW-1:0] r,
                                            input logic [NW-1:0] n);
        return h ? n - r : r + NW'(1);
    endfunction

    logic          fire, final_row, nx_half;
    logic [NW-1:0] s_cur, k_cur, nx_row, nx_s, n_eff, s_first;

    always_comb begin
        fire      = out_valid && out_ready;
        s_cur     = row_s(half, row, n_lat);
        k_cur     = row_k(half, row, n_lat);
        final_row = (row == n_lat - NW'(1)) &&
                    (half || mode_lat == 2'd0 || (mode_lat == 2'd3 && n_lat == NW'(1)));
        // Up half's last row hands over to the down half; compact diamond skips its widest row
        if (!half && row == n_lat - NW'(1)) begin
            nx_half = 1'b1;
            nx_row  = (mode_lat == 2'd3) ? NW'(1) : NW'(0);
        end else begin
            nx_half = half;
            nx_row  = row + NW'(1);
        end
        nx_s    = row_s(nx_half, nx_row, n_lat);
        n_eff   = (n_in > NW'(MAX_N)) ? NW'(MAX_N) : n_in;
        s_first = (mode == 2'd1) ? NW'(0) : n_eff - NW'(1);
    end

    // Next-state and next-output logic; everything holds unless a beat is accepted
    always_comb begin
        state_n    = state;
        row_n      = row;
        sp_cnt_n   = sp_cnt;
        st_cnt_n   = st_cnt;
        n_lat_n    = n_lat;
        half_n     = half;
        mode_lat_n = mode_lat;
        data_n     = out_data;
        valid_n    = out_valid;
        last_n     = out_last;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (n_in == NW'(0)) begin
                        err_n = 1'b1;
                    end else begin
                        n_lat_n    = n_eff;
                        mode_lat_n = mode;
                        half_n     = (mode == 2'd1);
                        row_n      = NW'(0);
                        valid_n    = 1'b1;
                        busy_n     = 1'b1;
                        last_n     = 1'b0;
                        if (s_first == NW'(0)) begin
                            state_n  = STAR;
                            data_n   = CH_STAR;
                            st_cnt_n = NW'(1);
                        end else begin
                            state_n  = SPC;
                            data_n   = CH_SP;
                            sp_cnt_n = NW'(1);
                        end
                    end
                end
            end
            SPC: if (fire) begin
                if (sp_cnt == s_cur) begin
                    state_n  = STAR;
                    data_n   = CH_STAR;
                    st_cnt_n = NW'(1);
                end else begin
                    sp_cnt_n = sp_cnt + NW'(1);
                end
            end
            STAR: if (fire) begin
                state_n = GAP;
                data_n  = CH_SP;
            end
            GAP: if (fire) begin
                if (st_cnt == k_cur) begin
                    state_n = EOL;
                    data_n  = CH_NL;
                    last_n  = final_row;
                end else begin
                    state_n  = STAR;
                    data_n   = CH_STAR;
                    st_cnt_n = st_cnt + NW'(1);
                end
            end
            EOL: if (fire) begin
                if (out_last) begin
                    state_n = IDLE;
                    data_n  = 8'h00;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    half_n = nx_half;
                    row_n  = nx_row;
                    if (nx_s == NW'(0)) begin
                        state_n  = STAR;
                        data_n   = CH_STAR;
                        st_cnt_n = NW'(1);
                    end else begin
                        state_n  = SPC;
                        data_n   = CH_SP;
                        sp_cnt_n = NW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            sp_cnt    <= '0;
            st_cnt    <= '0;
            n_lat     <= '0;
            half      <= 1'b0;
            mode_lat  <= 2'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            sp_cnt    <= sp_cnt_n;
            st_cnt    <= st_cnt_n;
            n_lat     <= n_lat_n;
            half      <= half_n;
            mode_lat  <= mode_lat_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule
